// File: rtl/l2_req_arbiter.sv
// ----------------------------------------------------------------------------
// l2_req_arbiter
//
// Arbitrates Icache, Dcache and L2-prefetcher requests onto the single L2
// request port. One transaction is held at a time: the winner's address and
// type are latched, presented to L2 while in REQ, and the L2 addrOK/dataOK
// handshakes are steered back to the winning source only.
//
// Priority is Dcache > Icache > prefetch, except that a pending Icache request
// that has lost STARVE_MAX consecutive arbitrations to the Dcache wins the
// next one.
//
// Ports
//   clk, rst                          clock, async active-high reset
//   icache_req/addr   -> addrOK/dataOK Icache request and handshake pulses
//   dcache_req/wr/addr-> addrOK/dataOK Dcache request and handshake pulses
//   pref_req/addr     -> addrOK/done   prefetch request (may be withdrawn)
//   l2_req/from/addr  <- l2_addrOK/dataOK  L2 request port and handshakes
//   busy                              high whenever a transaction is held
// ----------------------------------------------------------------------------
module l2_req_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        icache_req,
    input  logic [31:0] icache_addr,
    output logic        icache_addrOK,
    output logic        icache_dataOK,

    input  logic        dcache_req,
    input  logic        dcache_wr,
    input  logic [31:0] dcache_addr,
    output logic        dcache_addrOK,
    output logic        dcache_dataOK,

    input  logic        pref_req,
    input  logic [31:0] pref_addr,
    output logic        pref_addrOK,
    output logic        pref_done,

    output logic        l2_req,
    output logic [1:0]  l2_from,
    output logic [31:0] l2_addr,
    input  logic        l2_addrOK,
    input  logic        l2_dataOK,

    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_P    = 2'd1,
        SRC_I    = 2'd2,
        SRC_D    = 2'd3
    } src_t;

    // l2_from encoding seen by L2
    localparam logic [1:0] FROM_P  = 2'd0;
    localparam logic [1:0] FROM_I  = 2'd1;
    localparam logic [1:0] FROM_DR = 2'd2;
    localparam logic [1:0] FROM_DW = 2'd3;

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    state_t           state_q,  state_d;
    src_t             src_q,    src_d;
    logic [1:0]       from_q,   from_d;
    logic [31:0]      addr_q,   addr_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    // Source-agnostic handshake strobes; routed to the granted source below.
    logic addr_ok;
    logic data_ok;
    logic req_out;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            src_q    <= SRC_NONE;
            from_q   <= 2'd0;
            addr_q   <= 32'd0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            from_q   <= from_d;
            addr_q   <= addr_d;
            starve_q <= starve_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, arbitration and handshake strobes
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        from_d   = from_q;
        addr_d   = addr_q;
        starve_d = starve_q;
        addr_ok  = 1'b0;
        data_ok  = 1'b0;
        req_out  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Starvation override is checked first so a starved Icache
                // request beats a concurrent Dcache request.
                if (icache_req && (starve_q == STARVE_LIM)) begin
                    state_d  = ST_REQ;
                    src_d    = SRC_I;
                    from_d   = FROM_I;
                    addr_d   = icache_addr;
                    starve_d = '0;
                end else if (dcache_req) begin
                    state_d = ST_REQ;
                    src_d   = SRC_D;
                    from_d  = dcache_wr ? FROM_DW : FROM_DR;
                    addr_d  = dcache_addr;
                    // Count only arbitrations the Icache actually lost.
                    if (icache_req && (starve_q < STARVE_LIM))
                        starve_d = starve_q + CNT_W'(1);
                end else if (icache_req) begin
                    state_d  = ST_REQ;
                    src_d    = SRC_I;
                    from_d   = FROM_I;
                    addr_d   = icache_addr;
                    starve_d = '0;
                end else if (pref_req) begin
                    state_d = ST_REQ;
                    src_d   = SRC_P;
                    from_d  = FROM_P;
                    addr_d  = pref_addr;
                end
            end

            ST_REQ: begin
                if ((src_q == SRC_P) && !pref_req) begin
                    // Prefetcher withdrew before L2 accepted: drop the
                    // request silently, even if L2 answers this cycle.
                    state_d = ST_IDLE;
                    src_d   = SRC_NONE;
                end else begin
                    req_out = 1'b1;
                    if (l2_addrOK) begin
                        addr_ok = 1'b1;
                        if (l2_dataOK) begin
                            data_ok = 1'b1;
                            state_d = ST_IDLE;
                            src_d   = SRC_NONE;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end

            ST_WAIT: begin
                if (l2_dataOK) begin
                    data_ok = 1'b1;
                    state_d = ST_IDLE;
                    src_d   = SRC_NONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                src_d   = SRC_NONE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs: strobes are gated by the held grant, so non-granted sources
    // never see a pulse and handshakes in IDLE fall on the floor.
    // ------------------------------------------------------------------------
    assign icache_addrOK = addr_ok && (src_q == SRC_I);
    assign icache_dataOK = data_ok && (src_q == SRC_I);
    assign dcache_addrOK = addr_ok && (src_q == SRC_D);
    assign dcache_dataOK = data_ok && (src_q == SRC_D);
    assign pref_addrOK   = addr_ok && (src_q == SRC_P);
    assign pref_done     = data_ok && (src_q == SRC_P);

    assign l2_req  = req_out;
    assign l2_from = from_q;
    assign l2_addr = addr_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_l2_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_l2_req_arbiter
//
// Directed bench. Each phase pushes its hand-computed expected L2 requests
// and handshake pulses (with the absolute cycle they must appear in) onto a
// scoreboard queue; an independent monitor pops and compares whenever the
// DUT presents a new l2_req or any source pulse. Source models drop their
// request after seeing addrOK; an L2 model answers addrOK/dataOK a fixed
// number of cycles after the transaction enters REQ.
// ----------------------------------------------------------------------------
module tb_l2_req_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        icache_req = 1'b0, dcache_req = 1'b0, dcache_wr = 1'b0, pref_req = 1'b0;
    logic [31:0] icache_addr = '0, dcache_addr = '0, pref_addr = '0;
    logic        icache_addrOK, icache_dataOK, dcache_addrOK, dcache_dataOK;
    logic        pref_addrOK, pref_done;
    logic        l2_req, busy;
    logic [1:0]  l2_from;
    logic [31:0] l2_addr;
    logic        l2_addrOK = 1'b0, l2_dataOK = 1'b0;

    l2_req_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_addrOK(icache_addrOK), .icache_dataOK(icache_dataOK),
        .dcache_req(dcache_req), .dcache_wr(dcache_wr), .dcache_addr(dcache_addr),
        .dcache_addrOK(dcache_addrOK), .dcache_dataOK(dcache_dataOK),
        .pref_req(pref_req), .pref_addr(pref_addr),
        .pref_addrOK(pref_addrOK), .pref_done(pref_done),
        .l2_req(l2_req), .l2_from(l2_from), .l2_addr(l2_addr),
        .l2_addrOK(l2_addrOK), .l2_dataOK(l2_dataOK),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse vector bit positions: {i_a, i_d, d_a, d_d, p_a, p_d}
    localparam logic [5:0] PI_A = 6'b100000, PI_D = 6'b010000;
    localparam logic [5:0] PD_A = 6'b001000, PD_D = 6'b000100;
    localparam logic [5:0] PP_A = 6'b000010, PP_D = 6'b000001;

    typedef struct {
        logic        is_req;
        logic [1:0]  from;
        logic [31:0] addr;
        logic [5:0]  pulses;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bad(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic push_req(input logic [1:0] f, input logic [31:0] a, input int c);
        exp_t e;
        e.is_req = 1'b1; e.from = f; e.addr = a; e.pulses = '0; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic push_p(input logic [5:0] p, input int c);
        exp_t e;
        e.is_req = 1'b0; e.from = '0; e.addr = '0; e.pulses = p; e.cyc = c;
        sb.push_back(e);
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    logic req_prev = 1'b0;
    always @(negedge clk) begin : mon
        logic [5:0] pv;
        exp_t e;
        pv = {icache_addrOK, icache_dataOK, dcache_addrOK, dcache_dataOK, pref_addrOK, pref_done};
        if (l2_req && !req_prev) begin
            if (sb.size() == 0) bad("unexpected_l2_req");
            else begin
                e = sb.pop_front();
                chk("req_kind", 64'(!e.is_req), 64'(0));
                chk("req_from", 64'(l2_from), 64'(e.from));
                chk("req_addr", 64'(l2_addr), 64'(e.addr));
                chk("req_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (pv != 6'b0) begin
            if (sb.size() == 0) bad("unexpected_pulse");
            else begin
                e = sb.pop_front();
                chk("pulse_kind", 64'(e.is_req), 64'(0));
                chk("pulse_vec", 64'(pv), 64'(e.pulses));
                chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        req_prev = l2_req;
    end

    // ------------------------------------------------------------------------
    // Source and L2 models, advanced one cycle per step()
    // ------------------------------------------------------------------------
    int i_left = 0, d_left = 0, p_left = 0;
    int a_lat = 0, d_lat = 0, rc = 0;
    int p_drop_cyc = -1;
    logic was_busy = 1'b0;
    logic spam = 1'b0;

    task automatic step();
        logic s_ia, s_da, s_pa;
        @(negedge clk);
        s_ia = icache_addrOK; s_da = dcache_addrOK; s_pa = pref_addrOK;
        @(posedge clk);
        #1;
        if (s_ia) begin i_left--; icache_addr += 32'h40; end
        if (s_da) begin d_left--; dcache_addr += 32'h40; end
        if (s_pa) begin p_left--; pref_addr   += 32'h40; end
        if (cyc == p_drop_cyc) p_left = 0;
        icache_req = (i_left > 0);
        dcache_req = (d_left > 0);
        pref_req   = (p_left > 0);
        #1;
        if (busy && !was_busy) rc = 0;
        else if (busy) rc++;
        was_busy  = busy;
        l2_addrOK = (busy && rc == a_lat) || (spam && !busy);
        l2_dataOK = (busy && rc == d_lat) || (spam && !busy);
    endtask

    task automatic run(input string nm);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || i_left > 0 || d_left > 0 || p_left > 0) && n < 80) begin
            step();
            n++;
        end
        if (n >= 80) bad({nm, "_timeout"});
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int t0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_l2_req", 64'(l2_req), 64'(0));
        chk("rst_busy",   64'(busy),   64'(0));
        chk("rst_from",   64'(l2_from), 64'(0));
        chk("rst_addr",   64'(l2_addr), 64'(0));
        rst = 1'b0;

        // D read, addrOK 2 cycles into REQ, dataOK 5 cycles in
        d_left = 1; dcache_wr = 1'b0; dcache_addr = 32'h1000_0040; a_lat = 2; d_lat = 5;
        t0 = cyc + 1;
        push_req(2'd2, 32'h1000_0040, t0 + 1);
        push_p(PD_A, t0 + 3);
        push_p(PD_D, t0 + 6);
        run("d_read");

        // D write and I together, 2-cycle transactions: D first, then I
        d_left = 1; i_left = 1; dcache_wr = 1'b1;
        dcache_addr = 32'h2000_0000; icache_addr = 32'h0000_1000; a_lat = 0; d_lat = 0;
        t0 = cyc + 1;
        push_req(2'd3, 32'h2000_0000, t0 + 1);
        push_p(PD_A | PD_D, t0 + 1);
        push_req(2'd1, 32'h0000_1000, t0 + 3);
        push_p(PI_A | PI_D, t0 + 3);
        run("d_then_i");

        // Starvation: 4 D grants, then I, then D again
        d_left = 6; i_left = 1; dcache_wr = 1'b0;
        dcache_addr = 32'h3000_0000; icache_addr = 32'h0000_2000;
        t0 = cyc + 1;
        for (int k = 0; k < 7; k++) begin
            if (k == 4) begin
                push_req(2'd1, 32'h0000_2000, t0 + 1 + 2 * k);
                push_p(PI_A | PI_D, t0 + 1 + 2 * k);
            end else begin
                push_req(2'd2, 32'h3000_0000 + 32'h40 * ((k < 4) ? k : k - 1), t0 + 1 + 2 * k);
                push_p(PD_A | PD_D, t0 + 1 + 2 * k);
            end
        end
        run("starve");

        // Prefetch alone, addrOK then done two cycles later
        p_left = 1; pref_addr = 32'h4000_0080; a_lat = 1; d_lat = 3;
        t0 = cyc + 1;
        push_req(2'd0, 32'h4000_0080, t0 + 1);
        push_p(PP_A, t0 + 2);
        push_p(PP_D, t0 + 4);
        run("pref");

        // Prefetch withdrawn in REQ while L2 answers: cancel, no pulses
        p_left = 1; pref_addr = 32'h4000_1000; a_lat = 0; d_lat = 0;
        t0 = cyc + 1;
        p_drop_cyc = t0 + 1;
        step();
        step();
        chk("cancel_l2_req", 64'(l2_req), 64'(0));
        chk("cancel_busy_req", 64'(busy), 64'(1));
        chk("cancel_pulses", 64'({icache_addrOK, icache_dataOK, dcache_addrOK,
                                  dcache_dataOK, pref_addrOK, pref_done}), 64'(0));
        step();
        chk("cancel_idle", 64'(busy), 64'(0));
        p_drop_cyc = -1;

        // I with addrOK and dataOK in the same REQ cycle
        i_left = 1; icache_addr = 32'h0000_3000; a_lat = 0; d_lat = 0;
        t0 = cyc + 1;
        push_req(2'd1, 32'h0000_3000, t0 + 1);
        push_p(PI_A | PI_D, t0 + 1);
        run("i_combined");
        chk("i_combined_idle", 64'(cyc), 64'(t0 + 2));

        // L2 handshakes while IDLE are ignored
        spam = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_spam_busy", 64'(busy), 64'(0));
        end
        spam = 1'b0;

        // Async reset mid-WAIT
        d_left = 1; dcache_wr = 1'b0; dcache_addr = 32'h5000_0000; a_lat = 0; d_lat = 20;
        t0 = cyc + 1;
        push_req(2'd2, 32'h5000_0000, t0 + 1);
        push_p(PD_A, t0 + 1);
        step();
        step();
        step();
        chk("wait_busy", 64'(busy), 64'(1));
        #2;
        rst = 1'b1;
        l2_addrOK = 1'b1;
        l2_dataOK = 1'b1;
        #1;
        chk("rstw_l2_req", 64'(l2_req), 64'(0));
        chk("rstw_busy",   64'(busy),   64'(0));
        chk("rstw_from",   64'(l2_from), 64'(0));
        chk("rstw_addr",   64'(l2_addr), 64'(0));
        chk("rstw_pulses", 64'({icache_addrOK, icache_dataOK, dcache_addrOK,
                                dcache_dataOK, pref_addrOK, pref_done}), 64'(0));
        l2_addrOK = 1'b0;
        l2_dataOK = 1'b0;
        rc = 0;
        was_busy = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstw_sb_empty", 64'(sb.size()), 64'(0));

        // First request after reset: l2_req one cycle later
        d_left = 1; dcache_wr = 1'b1; dcache_addr = 32'h6000_0100; a_lat = 0; d_lat = 0;
        t0 = cyc + 1;
        push_req(2'd3, 32'h6000_0100, t0 + 1);
        push_p(PD_A | PD_D, t0 + 1);
        run("post_rst");

        repeat (2) @(posedge clk);
        chk("final_sb_empty", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/l2_req_arbiter.md
# l2_req_arbiter

Request arbiter and transaction sequencer in front of the L2 cache's single request port. It accepts requests from the Icache, the Dcache and the L2 prefetcher, and grants exactly one at a time. It holds the granted request stable toward L2 and routes the L2 addrOK/dataOK handshakes back to the granted source. Priority is Dcache over Icache over prefetch, with a starvation guard that forces an Icache grant after a bounded number of lost arbitrations.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive lost arbitrations after which a pending Icache request beats the Dcache (≥1).
- CNT_W, 3: starvation counter width; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- icache_req  in  1  Icache request; held high until icache_addrOK.
- icache_addr  in  32  Icache request address.
- icache_addrOK  out  1  one-cycle pulse: Icache request accepted by L2.
- icache_dataOK  out  1  one-cycle pulse: Icache data valid.
- dcache_req  in  1  Dcache request; held high until dcache_addrOK.
- dcache_wr  in  1  0 = read, 1 = write.
- dcache_addr  in  32  Dcache request address.
- dcache_addrOK  out  1  Dcache accept pulse.
- dcache_dataOK  out  1  Dcache completion pulse.
- pref_req  in  1  prefetch request; may drop at any time before pref_addrOK.
- pref_addr  in  32  prefetch address.
- pref_addrOK  out  1  prefetch accept pulse.
- pref_done  out  1  prefetch completion pulse.
- l2_req  out  1  request to L2, stable while in REQ.
- l2_from  out  2  0 = prefetch, 1 = I, 2 = D read, 3 = D write.
- l2_addr  out  32  latched address of the granted request.
- l2_addrOK  in  1  L2 accepted the request.
- l2_dataOK  in  1  L2 finished the request.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: no transaction held.
  - REQ: l2_req=1; the latched request is presented to L2.
  - WAIT: l2_req=0; the transaction is outstanding at L2.
- IDLE arbitration, combinational on the current request inputs:
  - If icache_req and starve_cnt == STARVE_MAX, grant I.
  - Otherwise grant D if dcache_req; else I if icache_req; else P if pref_req.
  - On a grant, latch grant source, l2_from (derived from dcache_wr for D) and address; go to REQ next cycle.
  - With no request, remain in IDLE.
- Starvation counter (starve_cnt, CNT_W bits):
  - On an IDLE grant to D while icache_req is high, increment, saturating at STARVE_MAX.
  - On a grant to I, clear to 0.
  - Otherwise hold.
- REQ:
  - l2_from and l2_addr come from the latches, not the live inputs.
  - When l2_addrOK=1, pulse the granted source's addrOK in the same cycle, combinationally gated by the grant.
  - If l2_dataOK=1 in that same cycle, also pulse the source's dataOK and go to IDLE; otherwise go to WAIT.
  - If the grant is P and pref_req has dropped before l2_addrOK: deassert l2_req, go to IDLE, emit no pulses (cancel).
- WAIT: when l2_dataOK=1, pulse the granted source's dataOK (pref_done for P) in the same cycle and go to IDLE.
- Pulse routing:
  - addrOK/dataOK outputs of non-granted sources are always 0.
  - L2 handshakes arriving in IDLE are ignored.
- Reset, at any time including mid-REQ or mid-WAIT:
  - State returns to IDLE; grant, latches and starve_cnt clear.
  - All outputs are 0 (l2_addr = 0, l2_from = 0); the outstanding transaction is abandoned.

## Timing
- Grant-to-L2 latency: request seen in IDLE at cycle n gives l2_req=1 at cycle n+1.
- addrOK and dataOK to the sources have zero added latency from l2_addrOK/l2_dataOK.
- Minimum transaction length is 2 cycles (IDLE grant, then REQ with addrOK and dataOK together).
- Back-to-back: after a dataOK cycle the state is IDLE next cycle, so arbitration for the next request happens then. There is one idle cycle for l2_req between transactions.
- busy is registered from state: 1 from the cycle after a grant through the dataOK cycle, inclusive.

## Test plan
- Reset: assert rst asynchronously mid-WAIT → all outputs 0 immediately; after release, a new dcache_req at cycle 0 gives l2_req=1 at cycle 1.
- D read: dcache_req=1, dcache_wr=0, addr 0x1000_0040; L2 gives addrOK at cycle 3 and dataOK at cycle 6 → l2_from=2, l2_addr=0x1000_0040; dcache_addrOK high only at cycle 3, dcache_dataOK high only at cycle 6, icache outputs stay 0.
- D and I asserted together, each completing in 2 cycles → D served first; I granted in the IDLE cycle after D's dataOK; starve_cnt=1 then 0.
- Starvation, STARVE_MAX=4: dcache_req and icache_req held continuously → four D grants, then the fifth grant goes to I (l2_from=1), then D again.
- Prefetch: pref_req alone → l2_from=0; addrOK/done pulses on the pref_* outputs. Then pref_req dropped in REQ before l2_addrOK → IDLE next cycle, no pulses.
- L2 returns l2_addrOK and l2_dataOK in the same REQ cycle for an I request → icache_addrOK and icache_dataOK pulse together; IDLE next cycle.
